input_event_irq: RTL and testbench

- Secondary-side input capture block carrying data from the FPGA to the GBA.
- Samples 8 external inputs (typically PB[7:0]), synchronizes and debounces them, and latches selected edges into W1C pending bits.
- Raises a level interrupt request while any enabled bit is pending.
- Exposes 4 registers in the cartridge address space through the Addr/Rd/Wr/DataRd path of Primary.

---
 rtl/input_event_irq.sv | 97 +++++++++
 tb/tb_input_event_irq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/input_event_irq.sv
// Input capture block: synchronizes and debounces eight inputs, latches selected edges into
// write-1-to-clear pending bits and raises a level interrupt for enabled pending bits.
module input_event_irq #(
    parameter logic [21:0] BASE     = 22'h3ff8c8,
    parameter logic [15:0] DEBOUNCE = 16'd50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [23:0] Addr,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] DataWr,
    output logic [15:0] DataRd,
    output logic        Sel,
    input  logic [7:0]  In,
    output logic        IrqReq
);

    localparam logic [15:0] LIMIT = DEBOUNCE - 16'd1;

    logic [7:0]  sync1_q, sync2_q;
    logic [7:0]  level_q, level_d;
    logic [7:0]  pending_q, pending_d;
    logic [7:0]  enable_q, edge_sel_q;
    logic [7:0]  event_hit, clear_mask;
    logic [15:0] cnt_q [8];
    logic [15:0] cnt_d [8];
    logic        wr_q, commit;
    logic        unused_bits;

    // Reads have no side effects, and the upper data byte is never stored.
    assign unused_bits = Rd ^ (^DataWr[15:8]);

    assign Sel    = (Addr[23:2] == BASE);
    assign commit = Wr & ~wr_q & Sel;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            level_d[i] = level_q[i];
            cnt_d[i]   = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == LIMIT) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
        // An event fires when the new level matches the selected direction (1 = rising).
        event_hit  = (level_d ^ level_q) & ~(level_d ^ edge_sel_q);
        clear_mask = (commit && Addr[1:0] == 2'd0) ? DataWr[7:0] : 8'h00;
        pending_d  = (pending_q & ~clear_mask) | event_hit;
    end

    always_comb begin
        DataRd = 16'h0000;
        if (Sel) begin
            unique case (Addr[1:0])
                2'd0: DataRd = {8'h00, pending_q};
                2'd1: DataRd = {8'h00, enable_q};
                2'd2: DataRd = {8'h00, level_q};
                2'd3: DataRd = {8'h00, edge_sel_q};
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            edge_sel_q <= 8'hff;
            wr_q       <= 1'b0;
            IrqReq     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= In;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            pending_q <= pending_d;
            wr_q      <= Wr;
            IrqReq    <= |(pending_q & enable_q);
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (commit) begin
                if (Addr[1:0] == 2'd1) enable_q   <= DataWr[7:0];
                if (Addr[1:0] == 2'd3) edge_sel_q <= DataWr[7:0];
            end
        end
    end

endmodule

// File: tb/tb_input_event_irq.sv
// Directed bench for input_event_irq with a short debounce window.
module tb_input_event_irq;

    localparam logic [21:0] BASE = 22'h3ff8c8;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [23:0] Addr = {BASE, 2'd0};
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] DataWr = 16'h0000;
    logic [15:0] DataRd;
    logic        Sel;
    logic [7:0]  In = 8'h00;
    logic        IrqReq;

    int n_tests = 0;
    int n_fail  = 0;

    input_event_irq #(
        .BASE     (BASE),
        .DEBOUNCE (16'd4)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Addr   (Addr),
        .Rd     (Rd),
        .Wr     (Wr),
        .DataWr (DataWr),
        .DataRd (DataRd),
        .Sel    (Sel),
        .In     (In),
        .IrqReq (IrqReq)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] off, input logic [15:0] exp);
        Addr = {BASE, off};
        Rd   = 1'b1;
        #1;
        check(tag, DataRd, exp);
        Rd   = 1'b0;
    endtask

    // One idle cycle guarantees a fresh strobe; the commit happens on the second edge.
    task automatic write(input logic [1:0] off, input logic [15:0] data);
        tick(1);
        Addr   = {BASE, off};
        DataWr = data;
        Wr     = 1'b1;
        tick(1);
        Wr     = 1'b0;
    endtask

    initial begin
        tick(3);
        Reset = 1'b1;
        tick(1);

        // 1: reset values and address decode
        check_reg("rst_status", 2'd0, 16'h0000);
        check_reg("rst_enable", 2'd1, 16'h0000);
        check_reg("rst_level",  2'd2, 16'h0000);
        check_reg("rst_edge",   2'd3, 16'h00ff);
        check("rst_irq", {15'd0, IrqReq}, 16'h0000);
        check("sel_hi", {15'd0, Sel}, 16'h0001);
        Addr = 24'h000003;
        #1;
        check("sel_lo", {15'd0, Sel}, 16'h0000);
        check("rd_unsel", DataRd, 16'h0000);

        // 2: glitch rejected, stable level accepted after 2+DEBOUNCE cycles
        tick(1);
        In = 8'h01;
        tick(3);
        In = 8'h00;
        tick(8);
        check_reg("glitch_level",  2'd2, 16'h0000);
        check_reg("glitch_status", 2'd0, 16'h0000);
        In = 8'h01;
        tick(5);
        check_reg("lvl_early", 2'd2, 16'h0000);
        tick(1);
        check_reg("lvl_at6",   2'd2, 16'h0001);
        check_reg("stat_rise", 2'd0, 16'h0001);
        check("irq_masked", {15'd0, IrqReq}, 16'h0000);
        tick(4);

        // 3: enable, W1C, read-only LEVEL, upper bits ignored
        write(2'd1, 16'hff01);
        check("irq_commit_cyc", {15'd0, IrqReq}, 16'h0000);
        check_reg("enable_rd", 2'd1, 16'h0001);
        tick(1);
        check("irq_on", {15'd0, IrqReq}, 16'h0001);
        write(2'd0, 16'h0000);
        check_reg("w1c_zero", 2'd0, 16'h0001);
        write(2'd2, 16'h00ff);
        check_reg("level_ro", 2'd2, 16'h0001);
        write(2'd0, 16'h0001);
        check_reg("w1c_clr", 2'd0, 16'h0000);
        check("irq_lag", {15'd0, IrqReq}, 16'h0001);
        tick(1);
        check("irq_off", {15'd0, IrqReq}, 16'h0000);

        // 4: edge selection
        In = 8'h00;
        tick(8);
        check_reg("fall_lvl",     2'd2, 16'h0000);
        check_reg("fall_ignored", 2'd0, 16'h0000);
        write(2'd3, 16'h00fe);
        check_reg("edge_rd", 2'd3, 16'h00fe);
        In = 8'h01;
        tick(8);
        check_reg("rise_lvl",     2'd2, 16'h0001);
        check_reg("rise_ignored", 2'd0, 16'h0000);
        In = 8'h00;
        tick(5);
        check_reg("fall_early", 2'd0, 16'h0000);
        tick(1);
        check_reg("fall_set", 2'd0, 16'h0001);
        tick(1);
        check("irq_fall", {15'd0, IrqReq}, 16'h0001);
        write(2'd0, 16'h0001);
        tick(1);
        check("irq_fall_clr", {15'd0, IrqReq}, 16'h0000);

        // 5: event and W1C on the same edge; the set wins
        In = 8'h08;
        tick(4);
        write(2'd0, 16'h0008);
        check_reg("race_lvl",    2'd2, 16'h0008);
        check_reg("race_status", 2'd0, 16'h0008);

        // 6: held strobe commits once
        tick(1);
        Addr   = {BASE, 2'd1};
        DataWr = 16'h0003;
        Wr     = 1'b1;
        tick(1);
        DataWr = 16'h0000;
        tick(4);
        Wr = 1'b0;
        tick(1);
        check_reg("hold_once", 2'd1, 16'h0003);
        check("irq_hold", {15'd0, IrqReq}, 16'h0000);
        write(2'd1, 16'h0008);
        tick(1);
        check("irq_pre_rst", {15'd0, IrqReq}, 16'h0001);

        // Reset mid-debounce
        In = 8'h28;
        tick(3);
        Reset = 1'b0;
        #1;
        check("irq_async_drop", {15'd0, IrqReq}, 16'h0000);
        check_reg("r2_status", 2'd0, 16'h0000);
        check_reg("r2_enable", 2'd1, 16'h0000);
        check_reg("r2_level",  2'd2, 16'h0000);
        check_reg("r2_edge",   2'd3, 16'h00ff);
        tick(2);
        Reset = 1'b1;
        tick(5);
        check_reg("r2_lvl_early", 2'd2, 16'h0000);
        tick(1);
        check_reg("r2_lvl",    2'd2, 16'h0028);
        check_reg("r2_stat",   2'd0, 16'h0028);
        check("r2_irq", {15'd0, IrqReq}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
